// File: rtl/lieat_exu_oitf_pkg.sv
// Shared widths and types for the EXU outstanding-instruction track FIFO.
// Optional macro LIEAT_OITF_PC_EN (used by the interface and top) adds per-entry PC storage.
package lieat_exu_oitf_pkg;

  localparam int XLEN       = 32;
  localparam int RD_W       = 5;
  localparam int OITF_DEPTH = 4;
  localparam int PTR_W      = $clog2(OITF_DEPTH);

  typedef logic [RD_W-1:0]  reg_idx_t;
  typedef logic [PTR_W-1:0] oitf_ptr_t;
  typedef logic [PTR_W:0]   oitf_cnt_t;
  typedef logic [XLEN-1:0]  xlen_t;

endpackage

// File: rtl/lieat_exu_oitf_if.sv
// Dispatch / retire / hazard-check bundle between the EXU and its OITF.
// head_pc exists only when LIEAT_OITF_PC_EN is defined.
interface lieat_exu_oitf_if;
  import lieat_exu_oitf_pkg::*;

  logic      dis_valid;
  logic      dis_ready;
  logic      dis_rd_en;
  reg_idx_t  dis_rd;
  xlen_t     dis_pc;
  oitf_ptr_t dis_id;
  logic      ret_valid;
  oitf_ptr_t ret_id;
  logic      chk_rs1_en;
  reg_idx_t  chk_rs1;
  logic      chk_rs2_en;
  reg_idx_t  chk_rs2;
  logic      chk_rd_en;
  reg_idx_t  chk_rd;
  logic      oitf_raw_dep;
  logic      oitf_waw_dep;
  oitf_ptr_t head_id;
  logic      head_rd_en;
  reg_idx_t  head_rd;
  logic      oitf_empty;
  logic      oitf_full;
  oitf_cnt_t oitf_cnt;
`ifdef LIEAT_OITF_PC_EN
  xlen_t     head_pc;
`endif

  modport master (
`ifdef LIEAT_OITF_PC_EN
    input  head_pc,
`endif
    output dis_valid, dis_rd_en, dis_rd, dis_pc, ret_valid, ret_id,
    output chk_rs1_en, chk_rs1, chk_rs2_en, chk_rs2, chk_rd_en, chk_rd,
    input  dis_ready, dis_id, oitf_raw_dep, oitf_waw_dep,
    input  head_id, head_rd_en, head_rd, oitf_empty, oitf_full, oitf_cnt
  );

  modport slave (
`ifdef LIEAT_OITF_PC_EN
    output head_pc,
`endif
    input  dis_valid, dis_rd_en, dis_rd, dis_pc, ret_valid, ret_id,
    input  chk_rs1_en, chk_rs1, chk_rs2_en, chk_rs2, chk_rd_en, chk_rd,
    output dis_ready, dis_id, oitf_raw_dep, oitf_waw_dep,
    output head_id, head_rd_en, head_rd, oitf_empty, oitf_full, oitf_cnt
  );

endinterface

// File: rtl/lieat_general_dfflr.sv
// Load-enabled register with optional synchronous active-low reset to zero.
module lieat_general_dfflr #(
  parameter int DW     = 1,
  parameter bit RST_EN = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);

  generate
    if (RST_EN) begin : g_rst
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      always_ff @(posedge clock) begin
        if (!reset)    qout <= '0;
        else if (lden) qout <= dnxt;
      end
    end else begin : g_norst
      logic unused_reset;
      assign unused_reset = reset;
      // NOTE: payload storage is left unreset; the separate valid bits decide whether it means anything.
      always_ff @(posedge clock) begin
        if (lden) qout <= dnxt;
      end
    end
  endgenerate

endmodule

// File: rtl/lieat_oitf_ptr.sv
// Wrap-flag pointer: PTR_W index bits plus a flag that toggles each lap of the FIFO.
module lieat_oitf_ptr #(
  parameter int PTR_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr,
  output logic             flag
);

  logic [PTR_W:0] cur;
  logic [PTR_W:0] nxt;

  // Depth is a power of two, so the carry out of the index bits is exactly the flag toggle.
  assign nxt = cur + 1'b1;

  lieat_general_dfflr #(.DW(PTR_W+1)) u_ptr_q (
    .clock (clock),
    .reset (reset),
    .lden  (inc),
    .dnxt  (nxt),
    .qout  (cur)
  );

  assign {flag, ptr} = cur;

endmodule

// File: rtl/lieat_exu_oitf.sv
// Outstanding Instruction Track FIFO: in-order allocate/retire plus RAW/WAW hazard flags.
// Define LIEAT_OITF_PC_EN to store each entry's PC and expose head_pc for commit tracing.
module lieat_exu_oitf
  import lieat_exu_oitf_pkg::*;
(
  input logic              clock,
  input logic              reset,
  lieat_exu_oitf_if.slave  bus
);

  oitf_ptr_t alloc_ptr, ret_ptr;
  logic      alloc_flag, ret_flag;
  logic      alloc_fire, ret_fire;
  logic      empty, full;

  logic [OITF_DEPTH-1:0]           vld;
  logic [OITF_DEPTH-1:0]           ent_rd_en;
  logic [OITF_DEPTH-1:0][RD_W-1:0] ent_rd;

  assign empty      = (alloc_ptr == ret_ptr) && (alloc_flag == ret_flag);
  assign full       = (alloc_ptr == ret_ptr) && (alloc_flag != ret_flag);
  assign alloc_fire = bus.dis_valid && !full;
  assign ret_fire   = bus.ret_valid && !empty && (bus.ret_id == ret_ptr);

  lieat_oitf_ptr #(.PTR_W(PTR_W)) u_alloc_ptr (
    .clock (clock), .reset (reset), .inc (alloc_fire), .ptr (alloc_ptr), .flag (alloc_flag)
  );

  lieat_oitf_ptr #(.PTR_W(PTR_W)) u_ret_ptr (
    .clock (clock), .reset (reset), .inc (ret_fire), .ptr (ret_ptr), .flag (ret_flag)
  );

`ifdef LIEAT_OITF_PC_EN
  logic [OITF_DEPTH-1:0][XLEN-1:0] ent_pc;
`else
  logic unused_dis_pc;
  assign unused_dis_pc = ^bus.dis_pc;
`endif

  generate
    for (genvar i = 0; i < OITF_DEPTH; i++) begin : g_ent
      localparam oitf_ptr_t IDX = oitf_ptr_t'(i);
      logic set, clr;

      // Alloc and retire never target the same slot in one cycle: that needs empty and non-empty at once.
      assign set = alloc_fire && (alloc_ptr == IDX);
      assign clr = ret_fire && (ret_ptr == IDX);

      lieat_general_dfflr #(.DW(1)) u_vld (
        .clock (clock), .reset (reset), .lden (set || clr), .dnxt (set), .qout (vld[i])
      );

      lieat_general_dfflr #(.DW(1+RD_W), .RST_EN(1'b0)) u_rd (
        .clock (clock), .reset (reset), .lden (set),
        .dnxt  ({bus.dis_rd_en && (bus.dis_rd != '0), bus.dis_rd}),
        .qout  ({ent_rd_en[i], ent_rd[i]})
      );

`ifdef LIEAT_OITF_PC_EN
      lieat_general_dfflr #(.DW(XLEN), .RST_EN(1'b0)) u_pc (
        .clock (clock), .reset (reset), .lden (set), .dnxt (bus.dis_pc), .qout (ent_pc[i])
      );
`endif
    end
  endgenerate

  // Only state from the previous edge is compared, so a same-cycle allocation never self-flags.
  always_comb begin
    // NOTE: defaults first so every path assigns both flags and no latch is inferred.
    bus.oitf_raw_dep = 1'b0;
    bus.oitf_waw_dep = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      if (vld[i] && ent_rd_en[i]) begin
        if ((bus.chk_rs1_en && ent_rd[i] == bus.chk_rs1) ||
            (bus.chk_rs2_en && ent_rd[i] == bus.chk_rs2))
          bus.oitf_raw_dep = 1'b1;
        if (bus.chk_rd_en && ent_rd[i] == bus.chk_rd)
          bus.oitf_waw_dep = 1'b1;
      end
    end
  end

  logic head_vld;
  assign head_vld = vld[ret_ptr] && reset;

  assign bus.head_id    = ret_ptr;
  assign bus.head_rd_en = head_vld && ent_rd_en[ret_ptr];
  assign bus.head_rd    = head_vld ? ent_rd[ret_ptr] : '0;
`ifdef LIEAT_OITF_PC_EN
  assign bus.head_pc    = head_vld ? ent_pc[ret_ptr] : '0;
`endif

  assign bus.dis_ready  = !full;
  assign bus.dis_id     = alloc_ptr;
  assign bus.oitf_empty = empty;
  assign bus.oitf_full  = full;
  assign bus.oitf_cnt   = {alloc_flag, alloc_ptr} - {ret_flag, ret_ptr};

endmodule
